// File: rtl/thor2023_memreq_arb_pkg.sv
// Thor2023Pkg: shared memory-request types, function codes and arbiter constants.
// Imported by the memory request arbiter and its grant selector.
package Thor2023Pkg;

  typedef enum logic [3:0] {
    MR_NOP         = 4'd0,
    MR_LOAD        = 4'd1,
    MR_LOADZ       = 4'd2,
    MR_STORE       = 4'd3,
    MR_ICACHE_LOAD = 4'd4,
    MR_CACHE       = 4'd5
  } memory_func_t;

  typedef struct packed {
    logic [7:0]   tid;
    memory_func_t func;
    logic [5:0]   tgt;
    logic         wr;
    logic [31:0]  adr;
    logic [31:0]  res;
  } memory_arg_t;

  // First transaction id after reset; id 0 is never issued.
  localparam logic [7:0] MEMARB_TID_FIRST = 8'd1;

  // Advance a transaction id, wrapping 255 back to the first id.
  function automatic logic [7:0] memarb_next_tid(input logic [7:0] tid);
    return (tid == 8'hFF) ? MEMARB_TID_FIRST : tid + 8'd1;
  endfunction

endpackage

// File: rtl/thor2023_memarb_sel.sv
// Grant selector for the memory request arbiter.
// Build macro THOR2023_MEMARB_RR_EN: when defined, round-robin between fetch
// and data; when undefined, data always beats instruction fetch.
module thor2023_memarb_sel
  import Thor2023Pkg::*;
(
`ifdef THOR2023_MEMARB_RR_EN
  input  logic clk_i,
  input  logic rst_i,
`endif
  input  logic grant_ok,
  input  logic ireq_v,
  input  logic dreq_v,
  output logic igrant,
  output logic dgrant
);

`ifdef THOR2023_MEMARB_RR_EN
  // d_pri_q high: data wins the next tie (reset points at data).
  logic d_pri_q;

  // Pick the requester; on a tie the last-granted side loses.
  always_comb begin
    igrant = 1'b0;
    dgrant = 1'b0;
    if (grant_ok) begin
      if (ireq_v && dreq_v) begin
        dgrant = d_pri_q;
        igrant = !d_pri_q;
      end else begin
        dgrant = dreq_v;
        igrant = ireq_v;
      end
    end
  end

  // Hand priority to the side that was not granted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      d_pri_q <= 1'b1;
    else if (igrant || dgrant)
      d_pri_q <= igrant;
  end
`else
  assign dgrant = grant_ok & dreq_v;
  assign igrant = grant_ok & ireq_v & ~dreq_v;
`endif

endmodule

// File: rtl/thor2023_memreq_arb.sv
// Memory request arbiter: merges fetch and load/store requests into the BIU
// request fifo, tags them with transaction ids, reads the BIU response fifo
// and routes responses back by function code.
// Build macro THOR2023_MEMARB_RR_EN selects round-robin arbitration.
module thor2023_memreq_arb
  import Thor2023Pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ireq_v_i,
  input  memory_arg_t ireq_i,
  output logic        ireq_rdy_o,
  input  logic        dreq_v_i,
  input  memory_arg_t dreq_i,
  output logic        dreq_rdy_o,
  output memory_arg_t memreq_o,
  input  logic        memreq_full_i,
  input  memory_arg_t memresp_i,
  input  logic        memresp_empty_i,
  output logic        memresp_rd_o,
  output logic        iresp_v_o,
  output memory_arg_t iresp_o,
  output logic        dresp_v_o,
  output memory_arg_t dresp_o,
  output logic [3:0]  outst_o,
  output logic        busy_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  logic        grant_ok;
  logic        igrant;
  logic        dgrant;
  logic        accept;
  logic        rd_pend;
  logic        resp_smp;
  logic [7:0]  tid_q;
  logic [3:0]  outst_q;
  memory_arg_t req_nxt;

  // A fifo write last cycle blocks granting this cycle.
  assign grant_ok = !memreq_full_i && (outst_q < MAX_CNT) && !memreq_o.wr;

  thor2023_memarb_sel u_sel (
`ifdef THOR2023_MEMARB_RR_EN
    .clk_i    (clk_i),
    .rst_i    (rst_i),
`endif
    .grant_ok (grant_ok),
    .ireq_v   (ireq_v_i),
    .dreq_v   (dreq_v_i),
    .igrant   (igrant),
    .dgrant   (dgrant)
  );

  assign ireq_rdy_o = igrant;
  assign dreq_rdy_o = dgrant;
  assign accept     = igrant | dgrant;
  assign resp_smp   = rd_pend;

  // Build the fifo entry: granted request with our tid and the write strobe.
  always_comb begin
    req_nxt     = dgrant ? dreq_i : ireq_i;
    req_nxt.tid = tid_q;
    req_nxt.wr  = 1'b1;
  end

  // Register the request; wr is a single-cycle strobe.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      memreq_o <= '0;
    else if (accept)
      memreq_o <= req_nxt;
    else
      memreq_o.wr <= 1'b0;
  end

  // Transaction id counter, skipping 0 on wrap.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      tid_q <= MEMARB_TID_FIRST;
    else if (accept)
      tid_q <= memarb_next_tid(tid_q);
  end

  // Pop one response at a time; data is sampled the cycle after the pop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      memresp_rd_o <= 1'b0;
      rd_pend      <= 1'b0;
    end else begin
      memresp_rd_o <= !memresp_empty_i && !rd_pend && !memresp_rd_o;
      rd_pend      <= memresp_rd_o;
    end
  end

  // Route sampled responses: fetch loads to the fetch port, all else to data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      iresp_v_o <= 1'b0;
      dresp_v_o <= 1'b0;
      iresp_o   <= '0;
      dresp_o   <= '0;
    end else begin
      iresp_v_o <= resp_smp && (memresp_i.func == MR_ICACHE_LOAD);
      dresp_v_o <= resp_smp && (memresp_i.func != MR_ICACHE_LOAD);
      if (resp_smp && (memresp_i.func == MR_ICACHE_LOAD))
        iresp_o <= memresp_i;
      if (resp_smp && (memresp_i.func != MR_ICACHE_LOAD))
        dresp_o <= memresp_i;
    end
  end

  // Outstanding count; a stray response at zero leaves the count at zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      outst_q <= 4'd0;
    else if (accept && !resp_smp)
      outst_q <= outst_q + 4'd1;
    else if (!accept && resp_smp && (outst_q != 4'd0))
      outst_q <= outst_q - 4'd1;
  end

  assign outst_o = outst_q;
  assign busy_o  = (outst_q != 4'd0);

endmodule

// File: tb/tb_thor2023_memreq_arb.sv
// Self-checking bench for thor2023_memreq_arb: a reference model predicts
// grants, tids and the outstanding count; a monitor scoreboards fifo writes
// and routed responses against queues filled when stimulus is issued.
module tb_thor2023_memreq_arb;
  import Thor2023Pkg::*;

  localparam int MAX_OUTST = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ireq_v_i = 1'b0;
  memory_arg_t ireq_i = '0;
  logic        ireq_rdy_o;
  logic        dreq_v_i = 1'b0;
  memory_arg_t dreq_i = '0;
  logic        dreq_rdy_o;
  memory_arg_t memreq_o;
  logic        memreq_full_i = 1'b0;
  memory_arg_t memresp_i = '0;
  logic        memresp_empty_i = 1'b1;
  logic        memresp_rd_o;
  logic        iresp_v_o;
  memory_arg_t iresp_o;
  logic        dresp_v_o;
  memory_arg_t dresp_o;
  logic [3:0]  outst_o;
  logic        busy_o;

  thor2023_memreq_arb #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ireq_v_i(ireq_v_i), .ireq_i(ireq_i), .ireq_rdy_o(ireq_rdy_o),
    .dreq_v_i(dreq_v_i), .dreq_i(dreq_i), .dreq_rdy_o(dreq_rdy_o),
    .memreq_o(memreq_o), .memreq_full_i(memreq_full_i),
    .memresp_i(memresp_i), .memresp_empty_i(memresp_empty_i), .memresp_rd_o(memresp_rd_o),
    .iresp_v_o(iresp_v_o), .iresp_o(iresp_o),
    .dresp_v_o(dresp_v_o), .dresp_o(dresp_o),
    .outst_o(outst_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  memory_arg_t exp_req_q[$];
  memory_arg_t exp_i_q[$];
  memory_arg_t exp_d_q[$];
  memory_arg_t fifo_q[$];

  // Reference model state
  int m_outst = 0;
  int m_tid   = 1;
  bit m_wrote = 0;
  bit m_dpri  = 1;
  int n_acc   = 0;
  bit pop_req = 0;
  bit pop_flag = 0;
  bit resp_en = 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input memory_arg_t r);
    fifo_q.push_back(r);
    memresp_empty_i = 1'b0;
    if (r.func == MR_ICACHE_LOAD) exp_i_q.push_back(r);
    else exp_d_q.push_back(r);
  endtask

  // Scoreboard monitor plus a memory that answers each fifo write.
  always @(negedge clk_i) begin
    memory_arg_t r;
    if (rst_i) begin
      pop_req = memresp_rd_o;
      if (memreq_o.wr) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL memreq_unexpected: got tid %0d expected no write", memreq_o.tid);
        end else chk("memreq", memreq_o, exp_req_q.pop_front());
        if (resp_en) begin
          r = memreq_o;
          r.wr = 1'b0;
          r.res = $urandom;
          expect_resp(r);
        end
      end
      if (iresp_v_o) begin
        if (exp_i_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL iresp_unexpected: got tid %0d expected none", iresp_o.tid);
        end else chk("iresp", iresp_o, exp_i_q.pop_front());
      end
      if (dresp_v_o) begin
        if (exp_d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dresp_unexpected: got tid %0d expected none", dresp_o.tid);
        end else chk("dresp", dresp_o, exp_d_q.pop_front());
      end
    end
  end

  // BIU response fifo: data appears the cycle after a read strobe.
  always @(posedge clk_i) begin
    #1;
    pop_flag = 0;
    if (pop_req && fifo_q.size() > 0) begin
      memresp_i = fifo_q.pop_front();
      pop_flag = 1;
    end
    pop_req = 0;
    memresp_empty_i = (fifo_q.size() == 0);
  end

  // One clock of stimulus: predict the grant, check, then advance the model.
  task automatic step();
    bit ok, acc_i, acc_d, acc;
    memory_arg_t r;
    @(negedge clk_i);
    ok = !memreq_full_i && (m_outst < MAX_OUTST) && !m_wrote;
    acc_i = 0;
    acc_d = 0;
    if (ok) begin
`ifdef THOR2023_MEMARB_RR_EN
      if (ireq_v_i && dreq_v_i) begin
        acc_d = m_dpri;
        acc_i = !m_dpri;
      end else begin
        acc_d = dreq_v_i;
        acc_i = ireq_v_i;
      end
`else
      acc_d = dreq_v_i;
      acc_i = ireq_v_i && !dreq_v_i;
`endif
    end
    chk("ireq_rdy_o", ireq_rdy_o, acc_i);
    chk("dreq_rdy_o", dreq_rdy_o, acc_d);
    chk("outst_o", outst_o, m_outst);
    chk("busy_o", busy_o, m_outst != 0);
    acc = acc_i | acc_d;
    if (acc) begin
      r = acc_d ? dreq_i : ireq_i;
      r.tid = m_tid[7:0];
      r.wr = 1'b1;
      exp_req_q.push_back(r);
    end
    @(posedge clk_i);
    if (acc && !pop_flag) m_outst++;
    else if (!acc && pop_flag && m_outst > 0) m_outst--;
    if (acc) begin
      m_tid = (m_tid == 255) ? 1 : m_tid + 1;
      n_acc++;
      m_dpri = acc_i;
    end
    m_wrote = acc;
    #1;
  endtask

  task automatic model_clear();
    exp_req_q.delete(); exp_i_q.delete(); exp_d_q.delete(); fifo_q.delete();
    m_outst = 0; m_tid = 1; m_wrote = 0; m_dpri = 1;
    pop_req = 0; pop_flag = 0;
    memresp_empty_i = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_memreq_o"}, memreq_o, 0);
    chk({tag, "_memresp_rd_o"}, memresp_rd_o, 0);
    chk({tag, "_iresp_v_o"}, iresp_v_o, 0);
    chk({tag, "_dresp_v_o"}, dresp_v_o, 0);
    chk({tag, "_iresp_o"}, iresp_o, 0);
    chk({tag, "_dresp_o"}, dresp_o, 0);
    chk({tag, "_outst_o"}, outst_o, 0);
    chk({tag, "_busy_o"}, busy_o, 0);
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_drain(input string tag);
    int n;
    ireq_v_i = 0; dreq_v_i = 0; memreq_full_i = 0;
    n = 0;
    while ((m_outst != 0 || exp_req_q.size() != 0 || exp_i_q.size() != 0 ||
            exp_d_q.size() != 0 || fifo_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_drain: got outst %0d expected drained within 200 cycles", tag, m_outst);
    end
  endtask

  function automatic memory_arg_t rand_req(input bit is_fetch);
    memory_arg_t r;
    int f;
    r = '0;
    r.adr = $urandom;
    r.tgt = 6'($urandom_range(0, 63));
    r.res = $urandom;
    r.tid = 8'($urandom);
    if (is_fetch) r.func = MR_ICACHE_LOAD;
    else begin
      f = $urandom_range(0, 2);
      r.func = (f == 0) ? MR_LOAD : (f == 1) ? MR_STORE : MR_LOADZ;
    end
    return r;
  endfunction

  initial begin
    memory_arg_t r;
    int t_rd, t_d, saw_i;

    // Reset state
    #2 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    chk("reset_ireq_rdy_o", ireq_rdy_o, 0);
    chk("reset_dreq_rdy_o", dreq_rdy_o, 0);
    release_reset();

    // First fetch request: accepted same cycle, tid 1 on the next
    ireq_i = '0;
    ireq_i.func = MR_ICACHE_LOAD;
    ireq_i.adr = 32'h1000;
    ireq_v_i = 1;
    step();
    ireq_v_i = 0;
    chk("first_wr", memreq_o.wr, 1);
    chk("first_adr", memreq_o.adr, 32'h1000);
    chk("first_tid", memreq_o.tid, 1);
    chk("first_outst", outst_o, 1);
    idle_drain("first");

    // Stray load response with nothing outstanding: routed to data port
    r = '0;
    r.func = MR_LOAD; r.tgt = 6'd5; r.res = 32'h1234; r.tid = 8'h77;
    expect_resp(r);
    t_rd = -1; t_d = -1; saw_i = 0;
    for (int k = 0; k < 10; k++) begin
      if (memresp_rd_o && t_rd < 0) t_rd = k;
      if (dresp_v_o && t_d < 0) begin
        t_d = k;
        chk("load_resp_res", dresp_o.res, 32'h1234);
      end
      if (iresp_v_o) saw_i = 1;
      step();
    end
    chk("load_resp_latency", t_d - t_rd, 2);
    chk("load_resp_no_iresp", saw_i, 0);
    chk("load_resp_outst", outst_o, 0);

    // Both requesters held valid for four grants
    ireq_i = rand_req(1);
    dreq_i = rand_req(0);
    ireq_v_i = 1; dreq_v_i = 1;
    repeat (8) step();
    idle_drain("contend");

    // Outstanding limit with responses withheld
    resp_en = 0;
    dreq_i = rand_req(0);
    dreq_v_i = 1;
    repeat (8) step();
    chk("limit_outst", outst_o, MAX_OUTST);
    chk("limit_dreq_rdy", dreq_rdy_o, 0);
    r = rand_req(0);
    expect_resp(r);
    repeat (8) step();
    dreq_v_i = 0;
    repeat (3) begin
      r = rand_req(0);
      expect_resp(r);
      repeat (4) step();
    end
    resp_en = 1;
    idle_drain("limit");

    // Request fifo full: no grant, no write
    memreq_full_i = 1;
    ireq_i = rand_req(1); dreq_i = rand_req(0);
    ireq_v_i = 1; dreq_v_i = 1;
    repeat (5) begin
      step();
      chk("full_no_wr", memreq_o.wr, 0);
    end
    memreq_full_i = 0;
    idle_drain("full");

    // Reset mid-burst clears outputs at once
    for (int k = 0; k < 12; k++) begin
      ireq_i = rand_req(1); dreq_i = rand_req(0);
      ireq_v_i = $urandom_range(0, 1); dreq_v_i = $urandom_range(0, 1);
      step();
    end
    #3 rst_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    ireq_v_i = 0; dreq_v_i = 0;
    model_clear();
    repeat (2) @(posedge clk_i);
    release_reset();
    r = rand_req(1);
    expect_resp(r);
    repeat (6) step();
    chk("post_rst_outst", outst_o, 0);

    // Randomized traffic, long enough to wrap the tid counter
    n_acc = 0;
    for (int k = 0; k < 4000 && n_acc < 300; k++) begin
      ireq_i = rand_req(1);
      dreq_i = rand_req(0);
      ireq_v_i = ($urandom_range(0, 1) == 1);
      dreq_v_i = ($urandom_range(0, 2) == 0);
      memreq_full_i = ($urandom_range(0, 7) == 0);
      step();
    end
    chk("random_accept_count_reached", n_acc >= 300, 1);
    idle_drain("random");
    chk("end_req_queue_empty", exp_req_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
